// File: rtl/lc4_arb_pkg.sv
// Shared types and constants for the LC4 data-port arbiter.
package lc4_arb_pkg;

  localparam int ARB_MAX_NREQ = 4;
  localparam int ARB_ID_W     = 2;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  typedef struct packed {
    logic                valid;
    logic [ARB_ID_W-1:0] id;
  } rsp_entry_t;

endpackage

// File: rtl/lc4_rr_pick.sv
// Rotating-priority encoder: first set bit of valid strictly after last_grant, wrapping.
module lc4_rr_pick
  import lc4_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]     valid,
  input  logic [ARB_ID_W-1:0] last_grant,
  output logic [NREQ-1:0]     grant,
  output logic [ARB_ID_W-1:0] grant_id,
  output logic                any
);

  int idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!any && valid[idx]) begin
        any        = 1'b1;
        grant_id   = ARB_ID_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lc4_dport_arbiter.sv
// Round-robin arbiter with RMW lock sharing the LC4 data port among NREQ requesters.
// Optional lock timeout is built when MEM_ARB_LOCK_TIMEOUT_EN is defined.
module lc4_dport_arbiter
  import lc4_arb_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int NREQ      = 2,
  parameter int READ_LAT  = 1,
  parameter int LOCK_MAX  = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      gwe,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0]           req_we,
  input  logic [NREQ-1:0]           req_lock,
  input  logic [NREQ*16-1:0]        req_addr,
  input  logic [NREQ*WORD_SIZE-1:0] req_wdata,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [WORD_SIZE-1:0]      rsp_rdata,
  output logic [15:0]               mem_daddr,
  output logic [WORD_SIZE-1:0]      mem_din,
  output logic                      mem_dwe,
  output logic                      mem_dre,
  input  logic [WORD_SIZE-1:0]      mem_dout,
  output logic                      lock_err
);

  arb_state_t            state;
  logic [ARB_ID_W-1:0]   owner;
  logic [ARB_ID_W-1:0]   last_grant;
  logic [ARB_ID_W-1:0]   gnt_id;
  logic [NREQ-1:0]       mask;
  logic [NREQ-1:0]       gnt;
  logic                  any;
  logic                  sel_we;
  logic                  sel_lock;
  logic [15:0]           sel_addr;
  logic [WORD_SIZE-1:0]  sel_wdata;
  logic [15:0]           addr_q;
  logic [WORD_SIZE-1:0]  din_q;
  rsp_entry_t            pipe [READ_LAT];

`ifdef MEM_ARB_LOCK_TIMEOUT_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  logic [CNT_W-1:0] lock_cnt;
  logic             lock_err_q;
  assign lock_err = lock_err_q;
`else
  assign lock_err = 1'b0;
`endif

  // While locked only the owner is eligible; nothing is eligible in reset or freeze.
  always_comb begin
    mask = '0;
    if (gwe && rst) begin
      if (state == ARB_LOCKED) mask[owner] = req_valid[owner];
      else                     mask = req_valid;
    end
  end

  lc4_rr_pick #(.NREQ(NREQ)) u_pick (
    .valid      (mask),
    .last_grant (last_grant),
    .grant      (gnt),
    .grant_id   (gnt_id),
    .any        (any)
  );

  always_comb begin
    sel_we    = req_we[int'(gnt_id)];
    sel_lock  = req_lock[int'(gnt_id)];
    sel_addr  = req_addr[int'(gnt_id)*16 +: 16];
    sel_wdata = req_wdata[int'(gnt_id)*WORD_SIZE +: WORD_SIZE];
  end

  assign req_ready = gnt;
  assign mem_dwe   = any & sel_we;
  assign mem_dre   = any & ~sel_we;
  assign mem_daddr = any ? sel_addr : addr_q;
  assign mem_din   = any ? sel_wdata : din_q;
  assign rsp_rdata = mem_dout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      owner      <= '0;
      last_grant <= ARB_ID_W'(NREQ - 1);
      addr_q     <= '0;
      din_q      <= '0;
`ifdef MEM_ARB_LOCK_TIMEOUT_EN
      lock_cnt   <= '0;
      lock_err_q <= 1'b0;
`endif
    end else if (gwe) begin
      if (any) begin
        last_grant <= gnt_id;
        addr_q     <= sel_addr;
        din_q      <= sel_wdata;
      end
      case (state)
        ARB_IDLE: begin
          if (any && sel_lock) begin
            state <= ARB_LOCKED;
            owner <= gnt_id;
`ifdef MEM_ARB_LOCK_TIMEOUT_EN
            lock_cnt <= '0;
`endif
          end
        end
        ARB_LOCKED: begin
          if (any && !sel_lock) state <= ARB_IDLE;
`ifdef MEM_ARB_LOCK_TIMEOUT_EN
          // A stuck owner loses the lock after LOCK_MAX locked cycles.
          if (lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
            state      <= ARB_IDLE;
            lock_err_q <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
`endif
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Read tags travel alongside the memory latency so data reaches its issuer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < READ_LAT; i++) pipe[i] <= '0;
    end else if (gwe) begin
      pipe[0] <= '{valid: any & ~sel_we, id: gnt_id};
      for (int i = 1; i < READ_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (gwe && pipe[READ_LAT-1].valid) rsp_valid[int'(pipe[READ_LAT-1].id)] = 1'b1;
  end

endmodule

// File: doc/lc4_dport_arbiter.md
Name: lc4_dport_arbiter

Overview:
- Shares the single data port of the LC4 memory (daddr/din/dout/dwe/dre) between NREQ requesters, e.g. core load/store, ECC scrubber, and a debug/DMA loader.
- Round-robin grant with one access per cycle, plus a lock for atomic read-modify-write.
- Read responses are routed back to the issuing requester after a fixed READ_LAT cycles.
- Sits between the requesters and lc4_memory; instruction and video ports are untouched.

Parameters:
- WORD_SIZE, 16, data width; matches the memory WORD_SIZE.
- NREQ, 2, number of requesters; legal range 2..4.
- READ_LAT, 1, cycles from read accept to mem_dout valid; legal range 1..8.
- LOCK_MAX, 64, maximum cycles a lock may be held; used only with the optional feature.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- gwe  in  1  global write enable; 0 freezes all state.
- req_valid  in  NREQ  request present, one bit per requester.
- req_ready  out  NREQ  grant; a transfer occurs when valid&ready.
- req_we  in  NREQ  1 = write, 0 = read.
- req_lock  in  NREQ  keep the grant after this transfer.
- req_addr  in  NREQ*16  packed addresses; requester i occupies [16*i+15:16*i].
- req_wdata  in  NREQ*WORD_SIZE  packed write data.
- rsp_valid  out  NREQ  read data valid for requester i.
- rsp_rdata  out  WORD_SIZE  read data, shared by all requesters.
- mem_daddr  out  16  to memory daddr.
- mem_din  out  WORD_SIZE  to memory din.
- mem_dwe  out  1  to memory dwe.
- mem_dre  out  1  to memory dre.
- mem_dout  in  WORD_SIZE  from memory dout.
- lock_err  out  1  sticky lock-timeout flag; tied 0 when the optional feature is off.

Behaviour:
- Reset (rst=0, async): last_grant=NREQ-1, so requester 0 wins first. State=IDLE, owner=0, response pipe cleared, lock_err=0. Outputs: req_ready=0, rsp_valid=0, mem_dwe=0, mem_dre=0, mem_daddr=0, mem_din=0.
- An in-flight read at reset is dropped; no rsp_valid is produced for it after reset.
- gwe=0: req_ready=0, mem_dwe=0, mem_dre=0. No register changes, including the response pipe and lock counter.
- Grant is combinational within the cycle. Exactly one req_ready bit may be high, and only if that requester's req_valid=1 and gwe=1.
- IDLE state: search from last_grant+1 modulo NREQ and pick the first valid requester g.
- A transfer drives mem_daddr/mem_din/mem_dwe=req_we[g]; mem_dre=~req_we[g]. It also sets last_grant<=g.
- IDLE with no valid requester: mem_dre=mem_dwe=0 and mem_daddr holds its last value.
- Lock entry: a transfer with req_lock[g]=1 moves IDLE->LOCKED with owner<=g.
- LOCKED state: only the owner can be granted. Owner valid=0 gives an idle cycle with the lock retained.
- Lock exit: an owner transfer with req_lock=0 moves LOCKED->IDLE. last_grant=owner, so a waiting peer wins next.
- Read response: the read transfer pushes (1, g) into a READ_LAT-deep shift pipe. rsp_valid[g]=1 exactly READ_LAT cycles after accept, with rsp_rdata=mem_dout.
- Back-to-back reads from different requesters return in issue order, one per cycle.
- Writes produce no response. A write followed next cycle by a read of the same address returns the new data; the memory handles this.
- rsp_rdata is don't-care when all rsp_valid bits are 0. The implementation drives mem_dout through unchanged.

Optional Feature:
- MEM_ARB_LOCK_TIMEOUT_EN defined:
  - A counter runs while in LOCKED and resets on lock entry.
  - When the counter reaches LOCK_MAX, force LOCKED->IDLE and set lock_err=1. lock_err clears only on reset.
  - The owner's next transfer is arbitrated normally.
- MEM_ARB_LOCK_TIMEOUT_EN undefined: no counter is built, a lock is held indefinitely, and lock_err is tied 0.

Decomposition:
- Package lc4_arb_pkg holds:
  - state enum {ARB_IDLE, ARB_LOCKED};
  - ARB_MAX_NREQ=4;
  - ARB_ID_W=2;
  - the response-pipe entry typedef {valid, id}.
- Sub-module lc4_rr_pick: combinational rotating-priority encoder with inputs (valid mask, last_grant) and outputs (grant one-hot, grant id, any).

Test Plan:
- Reset, then both requesters reading continuously (addr 0x0010 / 0x0020) -> grants alternate 0,1,0,1. rsp_valid[0] rises 1 cycle after each req-0 accept, with data matching preloaded memory.
- Req0 writes 0xBEEF@0x0040 with req_lock=1, then reads 0x0040 with lock=0, while req1 is valid throughout -> req1 ready=0 for both cycles. The read returns 0xBEEF and req1 is granted on the third cycle.
- gwe=0 for 3 cycles mid-stream with a read in flight -> no ready, no mem enables. rsp_valid is delayed exactly 3 cycles and the data is unchanged.
- Assert rst=0 asynchronously one cycle after a read accept -> rsp_valid stays 0. After release, req0 is granted first.
- NREQ=3, READ_LAT=2, requesters 1 and 2 valid only -> grants 1,2,1,2. Responses arrive 2 cycles after each accept, in issue order.
- With MEM_ARB_LOCK_TIMEOUT_EN, LOCK_MAX=8: req0 locks and then drops valid -> after 8 cycles lock_err=1 and req1 is granted. Without the macro, req1 is never granted.
